// File: rtl/fetch_sched_if.sv
// Hazard inputs and fetch-control outputs shared between the fetch sequencer and its neighbours.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface fetch_sched_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic            load_use_hz;
  logic            ext_stall;
  logic            load_next_pc;
  logic [XLEN-1:0] next_pc;
  logic            pc_en;
  logic            if_id_en;
  logic            if_id_flush;
  logic            id_ex_flush;

  modport master (
    output br_taken, br_target, load_use_hz, ext_stall,
    input  load_next_pc, next_pc, pc_en, if_id_en, if_id_flush, id_ex_flush
  );

  modport slave (
    input  br_taken, br_target, load_use_hz, ext_stall,
    output load_next_pc, next_pc, pc_en, if_id_en, if_id_flush, id_ex_flush
  );
endinterface

// File: rtl/fetch_sched.sv
// Fetch-stage sequencer: advance/hold/redirect decisions and IF/ID, ID/EX bubble insertion.
// Optional perf counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_sched #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int unsigned     FLUSH_CYCLES = 1,
  parameter int unsigned     CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  fetch_sched_if.slave     bus,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {StBoot = 2'd0, StRun = 2'd1, StStall = 2'd2, StFlush = 2'd3} state_e;

  localparam logic [2:0] FlushInit = 3'(FLUSH_CYCLES);

  state_e          state_q, state_d;
  logic [2:0]      fcnt_q, fcnt_d;
  logic            load_next_pc, pc_en, if_id_en, if_id_flush, id_ex_flush;
  logic [XLEN-1:0] next_pc;

  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    load_next_pc = 1'b0;
    next_pc      = '0;
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    unique case (state_q)
      StBoot: begin
        // Bubble covers the i_cache read of the first PC.
        if_id_en    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        next_pc     = RESET_PC;
        state_d     = StRun;
      end
      StRun, StStall: begin
        // A released STALL behaves exactly like RUN in the same cycle.
        if (bus.ext_stall) begin
          state_d = StStall;
        end else if (bus.br_taken) begin
          load_next_pc = 1'b1;
          next_pc      = bus.br_target;
          pc_en        = 1'b1;
          if_id_en     = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          fcnt_d       = FlushInit;
          state_d      = StFlush;
        end else if (bus.load_use_hz) begin
          id_ex_flush = 1'b1;
          state_d     = StRun;
        end else begin
          pc_en    = 1'b1;
          if_id_en = 1'b1;
          state_d  = StRun;
        end
      end
      StFlush: begin
        if (bus.ext_stall) begin
          state_d = StFlush;
        end else if (bus.br_taken) begin
          load_next_pc = 1'b1;
          next_pc      = bus.br_target;
          pc_en        = 1'b1;
          if_id_en     = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          fcnt_d       = FlushInit;
        end else begin
          // Decode holds a bubble here, so load_use_hz is meaningless.
          pc_en       = 1'b1;
          if_id_en    = 1'b1;
          if_id_flush = 1'b1;
          fcnt_d      = fcnt_q - 3'd1;
          if (fcnt_q == 3'd1) state_d = StRun;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StBoot;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign bus.load_next_pc = load_next_pc;
  assign bus.next_pc      = next_pc;
  assign bus.pc_en        = pc_en;
  assign bus.if_id_en     = if_id_en;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_flush  = id_ex_flush;
  assign state_o          = state_q;

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             count_stall;

  assign count_stall = !pc_en && (state_q == StRun || state_q == StStall);

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (count_stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (load_next_pc && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
